ifu_prefetch_buf: RTL and testbench

Parametrised instruction prefetch buffer that sits between the PC/fetch path and the IF/ID stage. It autonomously issues word fetches on the instruction bus and holds up to DEPTH fetched instructions with their addresses. On a jump/interrupt redirect it flushes all buffered and in-flight instructions. It replaces the single-register fetch path with a decoupled, depth-configurable stage that sustains one instruction per cycle on a 1-cycle-latency bus.

---
 rtl/ifu_prefetch_buf_if.sv | 32 +++
 rtl/ifu_prefetch_buf.sv | 135 +++++++++++++
 tb/tb_ifu_prefetch_buf.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_buf_if.sv
// Instruction fetch bus between the prefetch buffer (master) and memory (slave).
//   fetch_req_o    : request valid
//   fetch_addr_o   : word-aligned fetch address
//   fetch_gnt_i    : request accepted this cycle
//   fetch_rvalid_i : read data valid for the single outstanding request
//   fetch_rdata_i  : read data
interface ifu_prefetch_buf_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              fetch_req_o;
  logic [ADDR_W-1:0] fetch_addr_o;
  logic              fetch_gnt_i;
  logic              fetch_rvalid_i;
  logic [DATA_W-1:0] fetch_rdata_i;

  modport master (
    output fetch_req_o,
    output fetch_addr_o,
    input  fetch_gnt_i,
    input  fetch_rvalid_i,
    input  fetch_rdata_i
  );

  modport slave (
    input  fetch_req_o,
    input  fetch_addr_o,
    output fetch_gnt_i,
    output fetch_rvalid_i,
    output fetch_rdata_i
  );
endinterface

// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer: autonomously fetches sequential words and holds
// up to DEPTH instructions with their addresses; a jump flushes everything,
// including a request still in flight on the bus.
//   clk, rst       : clock, asynchronous active-high reset
//   bus            : fetch bus (master side)
//   jump_flag_i    : one-cycle redirect pulse, jump_addr_i = target
//   inst_valid_o   : head entry valid; inst_o / inst_addr_o = head entry
//   inst_ready_i   : consumer pops head
//   count_o        : number of buffered entries
module ifu_prefetch_buf #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  ifu_prefetch_buf_if.master         bus,
  input  logic                       jump_flag_i,
  input  logic [ADDR_W-1:0]          jump_addr_i,
  output logic                       inst_valid_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // IDLE: nothing on the bus; BUSY: one request awaiting data;
  // DROP: awaiting data that a jump has made stale.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic outstanding, discard, resp_accept, can_issue, fire, push, pop;
  logic unused_jump_lsb;

  assign outstanding = (state_q != S_IDLE);
  assign discard     = (state_q == S_DROP);
  assign resp_accept = bus.fetch_rvalid_i & outstanding & ~discard;

  // Only issue when a slot is guaranteed for the response, ignoring any pop.
  assign can_issue = (~outstanding | bus.fetch_rvalid_i) &
                     ((SUM_W'(count_q) + SUM_W'(resp_accept)) < SUM_W'(DEPTH));

  assign bus.fetch_req_o  = can_issue & ~jump_flag_i;
  assign bus.fetch_addr_o = fetch_pc_q;
  assign fire             = bus.fetch_req_o & bus.fetch_gnt_i;

  // A flush overrides any push or pop in the same cycle.
  assign push = resp_accept & ~jump_flag_i;
  assign pop  = (count_q != '0) & inst_ready_i & ~jump_flag_i;

  assign inst_valid_o    = (count_q != '0);
  assign inst_o          = mem_q[rd_ptr_q].data;
  assign inst_addr_o     = mem_q[rd_ptr_q].addr;
  assign count_o         = count_q;
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Outstanding-request tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Outstanding-request next state.
  always_comb begin
    state_d = state_q;
    if (jump_flag_i) begin
      state_d = (outstanding & ~bus.fetch_rvalid_i) ? S_DROP : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (fire) state_d = S_BUSY;
        S_BUSY:  if (fire) state_d = S_BUSY;
                 else if (bus.fetch_rvalid_i) state_d = S_IDLE;
        S_DROP:  if (bus.fetch_rvalid_i) state_d = fire ? S_BUSY : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Fetch PC and address of the request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else if (jump_flag_i) begin
      fetch_pc_q <= {jump_addr_i[ADDR_W-1:2], 2'b00};
    end else if (fire) begin
      req_addr_q <= fetch_pc_q;
      fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (jump_flag_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push & ~pop)      count_q <= count_q + CNT_W'(1);
      else if (pop & ~push) count_q <= count_q - CNT_W'(1);
    end
  end

  // FIFO storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{addr: req_addr_q, data: bus.fetch_rdata_i};
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Directed bench: DUT1 is DEPTH=4 / RESET_PC=0, DUT2 is DEPTH=2 / RESET_PC=0xFFFF_FFFC.
// A small bus slave answers each grant one cycle later unless held.
module tb_ifu_prefetch_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_prefetch_buf_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  ifu_prefetch_buf_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  logic        jump1, jump2, ready1, ready2, valid1, valid2;
  logic [31:0] jaddr1, jaddr2, inst1, inst2, iaddr1, iaddr2;
  logic [2:0]  cnt1;
  logic [1:0]  cnt2;

  ifu_prefetch_buf #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .jump_flag_i(jump1), .jump_addr_i(jaddr1),
    .inst_valid_o(valid1), .inst_o(inst1), .inst_addr_o(iaddr1),
    .inst_ready_i(ready1), .count_o(cnt1));

  ifu_prefetch_buf #(.DEPTH(2), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .jump_flag_i(jump2), .jump_addr_i(jaddr2),
    .inst_valid_o(valid2), .inst_o(inst2), .inst_addr_o(iaddr2),
    .inst_ready_i(ready2), .count_o(cnt2));

  int checks = 0;
  int errors = 0;
  int fires1, fires2;
  logic pend1, pend2, hold1, hold2;
  logic [31:0] pa1, pa2;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock: record handshakes, advance, then drive the slave response.
  task automatic tick();
    logic f1, f2, d1, d2;
    logic [31:0] a1, a2;
    d1 = bus1.fetch_rvalid_i; f1 = bus1.fetch_req_o & bus1.fetch_gnt_i; a1 = bus1.fetch_addr_o;
    d2 = bus2.fetch_rvalid_i; f2 = bus2.fetch_req_o & bus2.fetch_gnt_i; a2 = bus2.fetch_addr_o;
    if (f1) fires1++;
    if (f2) fires2++;
    @(posedge clk); #1;
    jump1 = 1'b0;
    if (d1) pend1 = 1'b0;
    if (f1) begin pend1 = 1'b1; pa1 = a1; end
    if (d2) pend2 = 1'b0;
    if (f2) begin pend2 = 1'b1; pa2 = a2; end
    bus1.fetch_rvalid_i = pend1 & ~hold1; bus1.fetch_rdata_i = mem_of(pa1);
    bus2.fetch_rvalid_i = pend2 & ~hold2; bus2.fetch_rdata_i = mem_of(pa2);
    #1;
  endtask

  // Reset both DUTs; returns in cycle 0 (first cycle after release).
  task automatic do_reset(input logic g, input logic r1, input logic r2);
    rst = 1'b1;
    jump1 = 1'b0; jaddr1 = '0; jump2 = 1'b0; jaddr2 = '0;
    pend1 = 1'b0; pend2 = 1'b0; hold1 = 1'b0; hold2 = 1'b0; pa1 = '0; pa2 = '0;
    bus1.fetch_rvalid_i = 1'b0; bus1.fetch_rdata_i = '0; bus1.fetch_gnt_i = g;
    bus2.fetch_rvalid_i = 1'b0; bus2.fetch_rdata_i = '0; bus2.fetch_gnt_i = g;
    ready1 = r1; ready2 = r2; fires1 = 0; fires2 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready1 = 1'b0; ready2 = 1'b0; jump1 = 1'b0; jump2 = 1'b0;
    jaddr1 = '0; jaddr2 = '0;
    bus1.fetch_gnt_i = 1'b0; bus1.fetch_rvalid_i = 1'b0; bus1.fetch_rdata_i = '0;
    bus2.fetch_gnt_i = 1'b0; bus2.fetch_rvalid_i = 1'b0; bus2.fetch_rdata_i = '0;
    #1;
    checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", cnt1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid1); end
    checks++; if (inst1 !== 32'h0 || iaddr1 !== 32'h0) begin errors++; $display("FAIL rst_head got %h/%h exp 0/0", inst1, iaddr1); end
    do_reset(1'b1, 1'b0, 1'b0);
    checks++; if (bus1.fetch_req_o !== 1'b1 || bus1.fetch_addr_o !== 32'h0) begin errors++; $display("FAIL rst_first_req got %b@%h exp 1@0", bus1.fetch_req_o, bus1.fetch_addr_o); end
    checks++; if (bus2.fetch_req_o !== 1'b1 || bus2.fetch_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_first_req2 got %b@%h exp 1@fffffffc", bus2.fetch_req_o, bus2.fetch_addr_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] ea;
    do_reset(1'b1, 1'b1, 1'b1);
    tick();  // cycle 1
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %b exp 0", valid1); end
    checks++; if (bus1.fetch_addr_o !== 32'h4) begin errors++; $display("FAIL stream_c1_addr got %h exp 4", bus1.fetch_addr_o); end
    checks++; if (bus2.fetch_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", bus2.fetch_addr_o); end
    for (int k = 2; k <= 7; k++) begin
      tick();
      ea = 32'(4 * (k - 2));
      checks++; if (valid1 !== 1'b1 || iaddr1 !== ea || inst1 !== mem_of(ea) || cnt1 !== 3'd1) begin
        errors++; $display("FAIL stream_c%0d got v=%b a=%h d=%h n=%0d exp v=1 a=%h d=%h n=1", k, valid1, iaddr1, inst1, cnt1, ea, mem_of(ea));
      end
      if (k == 2) begin
        checks++; if (valid2 !== 1'b1 || iaddr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_c2 got %b@%h exp 1@fffffffc", valid2, iaddr2); end
      end
      if (k == 3) begin
        checks++; if (valid2 !== 1'b1 || iaddr2 !== 32'h0 || inst2 !== mem_of(32'h0)) begin errors++; $display("FAIL wrap_c3 got %b@%h exp 1@0", valid2, iaddr2); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea;
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (8) tick();  // cycle 8
    checks++; if (cnt1 !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", cnt1); end
    checks++; if (bus1.fetch_req_o !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", bus1.fetch_req_o); end
    checks++; if (fires1 !== 4) begin errors++; $display("FAIL bp_grants got %0d exp 4", fires1); end
    checks++; if (iaddr1 !== 32'h0) begin errors++; $display("FAIL bp_head got %h exp 0", iaddr1); end
    checks++; if (cnt2 !== 2'd2 || fires2 !== 2) begin errors++; $display("FAIL bp2_count got %0d/%0d exp 2/2", cnt2, fires2); end
    checks++; if (iaddr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL bp2_head got %h exp fffffffc", iaddr2); end
    ready1 = 1'b1; ready2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ea = 32'(4 * k);
      checks++; if (valid1 !== 1'b1 || iaddr1 !== ea) begin errors++; $display("FAIL bp_drain%0d got %b@%h exp 1@%h", k, valid1, iaddr1, ea); end
      if (k == 1) begin
        checks++; if (bus1.fetch_req_o !== 1'b1 || bus1.fetch_addr_o !== 32'h10) begin errors++; $display("FAIL bp_resume got %b@%h exp 1@10", bus1.fetch_req_o, bus1.fetch_addr_o); end
        checks++; if (iaddr2 !== 32'h0 || bus2.fetch_req_o !== 1'b1 || bus2.fetch_addr_o !== 32'h4) begin errors++; $display("FAIL bp2_resume got %h req %b@%h exp 0 req 1@4", iaddr2, bus2.fetch_req_o, bus2.fetch_addr_o); end
      end
    end
  endtask

  task automatic test_jump_inflight();
    do_reset(1'b1, 1'b1, 1'b1);
    tick(); tick();  // cycle 2: request for 0x8 granted
    hold1 = 1'b1;
    tick();          // cycle 3: 0x8 outstanding, no data yet
    checks++; if (cnt1 !== 3'd1 || iaddr1 !== 32'h4) begin errors++; $display("FAIL jmp_pre got n=%0d a=%h exp n=1 a=4", cnt1, iaddr1); end
    jump1 = 1'b1; jaddr1 = 32'h103; #1;
    checks++; if (bus1.fetch_req_o !== 1'b0) begin errors++; $display("FAIL jmp_req_low got %b exp 0", bus1.fetch_req_o); end
    tick();          // cycle 4
    checks++; if (cnt1 !== 3'd0 || valid1 !== 1'b0 || bus1.fetch_req_o !== 1'b0) begin errors++; $display("FAIL jmp_flush got n=%0d v=%b r=%b exp 0/0/0", cnt1, valid1, bus1.fetch_req_o); end
    hold1 = 1'b0;
    tick();          // cycle 5: stale data arrives
    checks++; if (bus1.fetch_req_o !== 1'b1 || bus1.fetch_addr_o !== 32'h100) begin errors++; $display("FAIL jmp_target_req got %b@%h exp 1@100", bus1.fetch_req_o, bus1.fetch_addr_o); end
    tick();          // cycle 6
    checks++; if (cnt1 !== 3'd0 || valid1 !== 1'b0) begin errors++; $display("FAIL jmp_stale_drop got n=%0d v=%b exp 0/0", cnt1, valid1); end
    tick();          // cycle 7
    checks++; if (valid1 !== 1'b1 || iaddr1 !== 32'h100 || inst1 !== mem_of(32'h100)) begin errors++; $display("FAIL jmp_first got %b@%h d=%h exp 1@100 d=%h", valid1, iaddr1, inst1, mem_of(32'h100)); end
  endtask

  task automatic test_jump_coincident();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (4) tick();  // cycle 4: head 0x8, data for 0xC arriving, pop active
    checks++; if (iaddr1 !== 32'h8) begin errors++; $display("FAIL jc_pre got %h exp 8", iaddr1); end
    jump1 = 1'b1; jaddr1 = 32'h200; #1;
    checks++; if (bus1.fetch_req_o !== 1'b0) begin errors++; $display("FAIL jc_req_low got %b exp 0", bus1.fetch_req_o); end
    tick();             // cycle 5
    checks++; if (cnt1 !== 3'd0 || valid1 !== 1'b0) begin errors++; $display("FAIL jc_flush got n=%0d v=%b exp 0/0", cnt1, valid1); end
    checks++; if (bus1.fetch_req_o !== 1'b1 || bus1.fetch_addr_o !== 32'h200) begin errors++; $display("FAIL jc_target_req got %b@%h exp 1@200", bus1.fetch_req_o, bus1.fetch_addr_o); end
    tick();             // cycle 6
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL jc_no_stale got %b@%h exp 0", valid1, iaddr1); end
    tick();             // cycle 7
    checks++; if (valid1 !== 1'b1 || iaddr1 !== 32'h200) begin errors++; $display("FAIL jc_first got %b@%h exp 1@200", valid1, iaddr1); end
  endtask

  task automatic test_bus_stall();
    do_reset(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus1.fetch_req_o !== 1'b1 || bus1.fetch_addr_o !== 32'h0 || cnt1 !== 3'd0) begin
        errors++; $display("FAIL stall_c%0d got %b@%h n=%0d exp 1@0 n=0", k, bus1.fetch_req_o, bus1.fetch_addr_o, cnt1);
      end
      tick();
    end
    checks++; if (bus2.fetch_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL stall2_addr got %h exp fffffffc", bus2.fetch_addr_o); end
    bus1.fetch_gnt_i = 1'b1; bus2.fetch_gnt_i = 1'b1;
    tick();
    checks++; if (bus1.fetch_req_o !== 1'b1 || bus1.fetch_addr_o !== 32'h4) begin errors++; $display("FAIL stall_resume got %b@%h exp 1@4", bus1.fetch_req_o, bus1.fetch_addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    #2; rst = 1'b1; #1;
    checks++; if (cnt1 !== 3'd0 || valid1 !== 1'b0 || inst1 !== 32'h0 || iaddr1 !== 32'h0) begin
      errors++; $display("FAIL midrst got n=%0d v=%b d=%h a=%h exp all 0", cnt1, valid1, inst1, iaddr1);
    end
    checks++; if (bus1.fetch_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h exp 0", bus1.fetch_addr_o); end
    // Release with a stray response on the bus and no grants.
    bus1.fetch_gnt_i = 1'b0; bus2.fetch_gnt_i = 1'b0;
    pend1 = 1'b0; pend2 = 1'b0; hold1 = 1'b0; hold2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.fetch_rvalid_i = 1'b1; bus1.fetch_rdata_i = 32'hDEAD_BEEF;
    #1;
    tick();
    checks++; if (cnt1 !== 3'd0 || valid1 !== 1'b0) begin errors++; $display("FAIL stray_resp got n=%0d v=%b exp 0/0", cnt1, valid1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_jump_inflight();
    test_jump_coincident();
    test_bus_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
